// File: rtl/branch_predict_unit.sv
// Branch resolve unit with a 2-bit saturating-counter BHT for fetch-time prediction.
// Resolves branches/jumps one cycle after request and emits a flush pulse on mispredict.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  input  logic            valid_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] target_e,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      BrOp,
  input  logic            pred_taken_e,
  output logic            taken_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic            taken_q;
  logic            mispredict_q;
  logic [XLEN-1:0] redirect_q;
  logic [31:0]     branch_cnt_q;
  logic [31:0]     mispredict_cnt_q;

  logic            accept;
  logic            is_cond;
  logic            is_branch;
  logic            actual;
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;

  assign idx_f = pc_f[IDX_W+1:2];
  assign idx_e = pc_e[IDX_W+1:2];

  // While a flush pulse is out, the request in execute is from the wrong path.
  assign accept    = valid_e & ~mispredict_q;
  assign is_cond   = ~BrOp[4] & BrOp[3];
  assign is_branch = BrOp[4] | BrOp[3];

  always_comb begin
    actual = 1'b0;
    if (BrOp[4]) begin
      actual = 1'b1;
    end else if (BrOp[3]) begin
      case (BrOp[2:0])
        3'b000:  actual = (rs1 == rs2);
        3'b001:  actual = (rs1 != rs2);
        3'b100:  actual = ($signed(rs1) <  $signed(rs2));
        3'b101:  actual = ($signed(rs1) >= $signed(rs2));
        3'b110:  actual = (rs1 <  rs2);
        3'b111:  actual = (rs1 >= rs2);
        default: actual = 1'b0;
      endcase
    end
  end

  // One counter per entry; only conditional branches train the table.
  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      always_ff @(posedge clk) begin
        if (rst) begin
          bht_q[gi] <= 2'b01;
        end else if (accept && is_cond && (idx_e == IDX_W'(gi))) begin
          if (actual && (bht_q[gi] != 2'b11)) begin
            bht_q[gi] <= bht_q[gi] + 2'd1;
          end else if (!actual && (bht_q[gi] != 2'b00)) begin
            bht_q[gi] <= bht_q[gi] - 2'd1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q          <= 1'b0;
      mispredict_q     <= 1'b0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (accept) begin
      taken_q      <= actual;
      mispredict_q <= (actual != pred_taken_e);
      redirect_q   <= actual ? target_e : (pc_e + XLEN'(4));
      if (is_branch) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (actual != pred_taken_e) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end else begin
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
    end
  end

  assign pred_taken_f     = bht_q[idx_f][1];
  assign taken_o          = taken_q;
  assign mispredict_o     = mispredict_q;
  assign redirect_pc_o    = redirect_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a behavioural model is checked every cycle,
// and literal expectations pin the model at key points.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic        valid_e;
  logic [31:0] pc_e;
  logic [31:0] target_e;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  BrOp;
  logic        pred_taken_e;
  logic        taken_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_f             (pc_f),
    .pred_taken_f     (pred_taken_f),
    .valid_e          (valid_e),
    .pc_e             (pc_e),
    .target_e         (target_e),
    .rs1              (rs1),
    .rs2              (rs2),
    .BrOp             (BrOp),
    .pred_taken_e     (pred_taken_e),
    .taken_o          (taken_o),
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_JAL  = 5'b10000;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BGE  = 5'b01101;
  localparam logic [4:0] OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit          m_ok = 1'b0;
  int          m_bht [16];
  bit          m_taken;
  bit          m_mis;
  logic [31:0] m_redir;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit outcome(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (op[4]) return 1'b1;
    if (!op[3]) return 1'b0;
    case (op[2:0])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  // Reference model advanced on each rising edge from the inputs held there.
  always @(posedge clk) begin
    bit act;
    if (rst) begin
      m_ok = 1'b1;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_taken = 0; m_mis = 0; m_redir = 0; m_bcnt = 0; m_mcnt = 0;
    end else if (valid_e && !m_mis) begin
      act = outcome(BrOp, rs1, rs2);
      if (BrOp[4] == 1'b0 && BrOp[3] == 1'b1) begin
        if (act) m_bht[bidx(pc_e)] = (m_bht[bidx(pc_e)] < 3) ? m_bht[bidx(pc_e)] + 1 : 3;
        else     m_bht[bidx(pc_e)] = (m_bht[bidx(pc_e)] > 0) ? m_bht[bidx(pc_e)] - 1 : 0;
      end
      if (BrOp[4] || BrOp[3]) m_bcnt = m_bcnt + 1;
      m_taken = act;
      m_mis   = (act != pred_taken_e);
      if (m_mis) m_mcnt = m_mcnt + 1;
      m_redir = act ? target_e : pc_e + 32'd4;
    end else begin
      m_taken = 0;
      m_mis   = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("taken_o",          {31'd0, taken_o},      {31'd0, m_taken});
      check("mispredict_o",     {31'd0, mispredict_o}, {31'd0, m_mis});
      check("redirect_pc_o",    redirect_pc_o,         m_redir);
      check("branch_cnt_o",     branch_cnt_o,          m_bcnt);
      check("mispredict_cnt_o", mispredict_cnt_o,      m_mcnt);
      check("pred_taken_f",     {31'd0, pred_taken_f}, {31'd0, m_bht[bidx(pc_f)] >= 2});
    end
  end

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pr);
    valid_e = 1'b1; BrOp = op; rs1 = a; rs2 = b; pc_e = pc; target_e = tgt; pred_taken_e = pr;
    @(posedge clk); #1;
    valid_e = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'h0; valid_e = 1'b0; pc_e = 0; target_e = 0;
    rs1 = 0; rs2 = 0; BrOp = OP_NONE; pred_taken_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst taken_o", {31'd0, taken_o}, 32'd0);
    check("rst redirect", redirect_pc_o, 32'd0);
    check("rst bcnt", branch_cnt_o, 32'd0);
    for (int i = 0; i < 16; i++) begin
      pc_f = i * 4; #1;
      check("rst pred_taken_f", {31'd0, pred_taken_f}, 32'd0);
    end
    rst = 1'b0;
    pc_f = 32'h100;

    // BEQ equal, predicted not-taken
    drive(OP_BEQ, 5, 5, 32'h100, 32'h180, 1'b0);
    check("beq taken", {31'd0, taken_o}, 32'd1);
    check("beq mis", {31'd0, mispredict_o}, 32'd1);
    check("beq redirect", redirect_pc_o, 32'h180);
    check("beq bcnt", branch_cnt_o, 32'd1);
    check("beq mcnt", mispredict_cnt_o, 32'd1);
    check("beq pred_f", {31'd0, pred_taken_f}, 32'd1);
    gap();
    check("hold redirect", redirect_pc_o, 32'h180);
    check("idle mis", {31'd0, mispredict_o}, 32'd0);

    drive(OP_BLT, -5, 3, 32'h200, 32'h300, 1'b1);
    check("blt taken", {31'd0, taken_o}, 32'd1);
    gap();
    drive(OP_BLTU, 32'h1, 32'hFFFFFF00, 32'h204, 32'h310, 1'b1);
    check("bltu taken", {31'd0, taken_o}, 32'd1);
    gap();
    drive(OP_BGEU, 32'hFFFFFF00, 32'h1, 32'h208, 32'h320, 1'b1);
    check("bgeu taken", {31'd0, taken_o}, 32'd1);
    gap();
    drive(OP_BGE, -1, 10, 32'h20C, 32'h330, 1'b1);
    check("bge taken", {31'd0, taken_o}, 32'd0);
    check("bge redirect", redirect_pc_o, 32'h210);
    gap();

    // BNE training at 0x20
    pc_f = 32'h20;
    for (int k = 0; k < 4; k++) begin
      drive(OP_BNE, 1, 2, 32'h20, 32'h80, pred_taken_f);
      gap();
    end
    check("bne sat pred", {31'd0, pred_taken_f}, 32'd1);
    drive(OP_BNE, 7, 7, 32'h20, 32'h80, 1'b1);
    check("bne nt1 pred", {31'd0, pred_taken_f}, 32'd1);
    gap();
    drive(OP_BNE, 7, 7, 32'h20, 32'h80, 1'b1);
    check("bne nt2 pred", {31'd0, pred_taken_f}, 32'd0);
    gap();

    // Saturation at 00 and recovery at 0x30
    pc_f = 32'h30;
    for (int k = 0; k < 3; k++) begin
      drive(OP_BEQ, 1, 2, 32'h30, 32'h90, 1'b0);
    end
    drive(OP_BEQ, 3, 3, 32'h30, 32'h90, 1'b0);
    check("sat00 pred", {31'd0, pred_taken_f}, 32'd0);
    gap();

    // Wrong-path request held during the flush pulse
    begin
      logic [31:0] b0;
      b0 = branch_cnt_o;
      valid_e = 1'b1; BrOp = OP_JAL; pc_e = 32'h40; target_e = 32'h400; pred_taken_e = 1'b0;
      @(posedge clk); #1;
      check("jal mis", {31'd0, mispredict_o}, 32'd1);
      check("jal bcnt", branch_cnt_o, b0 + 32'd1);
      @(posedge clk); #1;
      check("wrongpath mis", {31'd0, mispredict_o}, 32'd0);
      check("wrongpath bcnt", branch_cnt_o, b0 + 32'd1);
      check("wrongpath redirect", redirect_pc_o, 32'h400);
      valid_e = 1'b0;
      gap();
    end

    // Non-branch predicted taken at top of address space
    begin
      logic [31:0] b0;
      b0 = branch_cnt_o;
      pc_f = 32'hFFFFFFFC;
      drive(OP_NONE, 0, 0, 32'hFFFFFFFC, 32'h1234, 1'b1);
      check("nonbr redirect", redirect_pc_o, 32'h0);
      check("nonbr mis", {31'd0, mispredict_o}, 32'd1);
      check("nonbr taken", {31'd0, taken_o}, 32'd0);
      check("nonbr bcnt", branch_cnt_o, b0);
      check("nonbr pred_f", {31'd0, pred_taken_f}, 32'd0);
      gap();
    end

    // Reset overriding an accepted mispredicting BEQ
    pc_f = 32'h100;
    rst = 1'b1;
    drive(OP_BEQ, 9, 9, 32'h100, 32'h180, 1'b0);
    rst = 1'b0;
    check("rstov taken", {31'd0, taken_o}, 32'd0);
    check("rstov mis", {31'd0, mispredict_o}, 32'd0);
    check("rstov redirect", redirect_pc_o, 32'd0);
    check("rstov bcnt", branch_cnt_o, 32'd0);
    check("rstov mcnt", mispredict_cnt_o, 32'd0);
    check("rstov pred_f", {31'd0, pred_taken_f}, 32'd0);
    drive(OP_BEQ, 1, 2, 32'h100, 32'h180, 1'b0);
    check("post rst pred_f", {31'd0, pred_taken_f}, 32'd0);
    gap();
    gap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of operands and PCs.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit predictor counters; power of two, at least 2.
REQ-003 SHALL have one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pc_f  input  XLEN  fetch PC for lookup
- pred_taken_f  output  1  prediction for pc_f (combinational)
- valid_e  input  1  resolve request
- pc_e  input  XLEN  PC of the resolving instruction
- target_e  input  XLEN  computed branch/jump target
- rs1  input  XLEN  operand A
- rs2  input  XLEN  operand B
- BrOp  input  5  branch opcode
- pred_taken_e  input  1  prediction carried down from fetch
- taken_o  output  1  registered actual outcome
- mispredict_o  output  1  registered one-cycle flush pulse
- redirect_pc_o  output  XLEN  registered correct next PC
- branch_cnt_o  output  32  resolved branch/jump count
- mispredict_cnt_o  output  32  mispredict count

Function
REQ-005 SHALL decode BrOp as follows:
- BrOp[4]=1: unconditional taken.
- Else BrOp[3]=1: conditional, selected by BrOp[2:0]: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; 010/011 not taken.
- Else: not a branch, not taken.
REQ-006 SHALL index the BHT with pc[log2(BHT_ENTRIES)+1:2], ignoring PC bits [1:0].
REQ-007 SHALL drive pred_taken_f = bit 1 of the counter indexed by pc_f, read combinationally from the current register contents.
REQ-008 SHALL accept a resolve when valid_e=1 and mispredict_o=0. When mispredict_o=1, valid_e is a wrong-path request: ignored, with no state, counter or output change except the pulse drop.
REQ-009 On an accepted resolve, SHALL register on the next rising edge (latency 1):
- taken_o = actual outcome.
- mispredict_o = (actual != pred_taken_e).
- redirect_pc_o = actual ? target_e : pc_e+4, computed mod 2^XLEN.
REQ-010 When no resolve is accepted, SHALL drive taken_o=0 and mispredict_o=0 on the next edge; redirect_pc_o SHALL hold its value.
REQ-011 A non-branch BrOp with pred_taken_e=1 SHALL produce mispredict_o=1 and redirect_pc_o=pc_e+4.
REQ-012 On an accepted conditional resolve (BrOp[4]=0, BrOp[3]=1), SHALL update the counter indexed by pc_e: saturating increment if taken, saturating decrement if not; 11 stays 11, 00 stays 00. Unconditional and non-branch resolves SHALL NOT update the BHT.
REQ-013 A same-cycle lookup and update to the same index SHALL return the pre-update value on pred_taken_f; the new value is visible from the next cycle.
REQ-014 branch_cnt_o SHALL increment by 1 per accepted resolve with BrOp[4]|BrOp[3]=1. mispredict_cnt_o SHALL increment by 1 per accepted resolve that sets mispredict_o. Both SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 Counter increments SHALL appear on the same edge as the registered outputs.

Reset
REQ-016 While rst=1 at a clock edge, SHALL set:
- all BHT counters to 01 (weakly not-taken)
- taken_o=0, mispredict_o=0, redirect_pc_o=0
- both counts=0
REQ-017 rst SHALL override an accepted resolve in the same cycle: no update, no count, outputs take reset values.
REQ-018 After reset, pred_taken_f SHALL be 0 for every pc_f.

Verification
REQ-019 Reset, then BEQ with rs1=5, rs2=5, pred_taken_e=0, pc_e=0x100, target_e=0x180 -> next cycle: taken_o=1, mispredict_o=1, redirect_pc_o=0x180, branch_cnt_o=1, mispredict_cnt_o=1; BHT[0] becomes 10, so pred_taken_f=1 for pc_f=0x100.
REQ-020 BLT with rs1=-5, rs2=3 -> taken_o=1. BLTU with rs1=0x1, rs2=0xFFFFFF00 -> taken_o=1. BGEU with rs1=0xFFFFFF00, rs2=0x1 -> taken_o=1. BGE with rs1=-1, rs2=10 -> taken_o=0.
REQ-021 Four taken BNE resolves at pc_e=0x20 -> counter saturates at 11; one not-taken -> 10, pred_taken_f still 1; second not-taken -> 01, pred_taken_f=0.
REQ-022 Mispredict at cycle N with valid_e=1 held at cycle N+1 (JAL, pred_taken_e=0) -> cycle N+1 request ignored: mispredict_o=0 at N+2 and branch_cnt_o unchanged.
REQ-023 JAL at pc_e=0xFFFFFFFC, not taken path check -> non-branch BrOp=00000 with pred_taken_e=1 at that PC gives redirect_pc_o=0x00000000 (wrap) and mispredict_o=1; BHT unchanged.
REQ-024 rst asserted in the same cycle as an accepted BEQ mispredict -> all outputs and counts 0, BHT entry stays 01.
